// File: rtl/fp_custom_pkg.sv
// Field layout, classes and flag positions shared by the custom-float to IEEE-754 converter.
package fp_custom_pkg;

    localparam int SIGN        = 1;
    localparam int EXP_W       = 6;
    localparam int MAN_W       = 25;
    localparam int BIAS_CUSTOM = 31;
    localparam int BIAS_IEEE   = 127;
    localparam int IEEE_W      = 32;
    localparam int STATUS_W    = 4;
    localparam int FLAG_W      = 4;

    localparam int FLAG_INEXACT = 0;
    localparam int FLAG_ZERO    = 1;
    localparam int FLAG_INF     = 2;
    localparam int FLAG_NAN     = 3;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } custom_fp_t;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

    // Denormals are flushed: a zero exponent is a zero regardless of mantissa.
    function automatic fp_class_t classify(input custom_fp_t f);
        if (f.exp == '0)
            return ZERO;
        else if (f.exp == EXP_MAX)
            return (f.man == '0) ? INF : NAN;
        else
            return NORMAL;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round and pack of a classified custom float into an IEEE-754 binary32 word.
// FP_CONV_ROUND_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_round_pack
    import fp_custom_pkg::*;
#(
    parameter logic [IEEE_W-1:0] NAN_PATTERN = 32'h7FC0_0000
) (
    input  logic              sign,
    input  fp_class_t         cls,
    input  logic [EXP_W-1:0]  exp,
    input  logic [MAN_W-1:0]  man,
    output logic [IEEE_W-1:0] data,
    output logic [FLAG_W-1:0] flags
);

    localparam logic [7:0] EXP_OFFSET = 8'(BIAS_IEEE - BIAS_CUSTOM);

    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_rnd;
    logic [7:0]  exp8;
    logic [7:0]  exp_rnd;

    assign frac   = man[MAN_W-1:2];
    assign guard  = man[1];
    assign sticky = man[0];

`ifdef FP_CONV_ROUND_RNE_EN
    assign round_up = guard & (sticky | frac[0]);
`else
    assign round_up = 1'b0;
`endif

    // Biased exponent stays within 97..159, so the carry bump can never overflow into Inf.
    assign frac_rnd = {1'b0, frac} + {23'b0, round_up};
    assign exp8     = {2'b00, exp} + EXP_OFFSET;
    assign exp_rnd  = exp8 + {7'b0, frac_rnd[23]};

    always_comb begin
        data  = '0;
        flags = '0;
        case (cls)
            ZERO: begin
                data            = {sign, 31'b0};
                flags[FLAG_ZERO] = 1'b1;
            end
            INF: begin
                data            = {sign, 8'hFF, 23'b0};
                flags[FLAG_INF] = 1'b1;
            end
            NAN: begin
                data            = NAN_PATTERN;
                flags[FLAG_NAN] = 1'b1;
            end
            default: begin
                data                = {sign, exp_rnd, frac_rnd[22:0]};
                flags[FLAG_INEXACT] = guard | sticky;
            end
        endcase
    end

endmodule

// File: rtl/fp_result_ieee_conv.sv
// Two-stage valid/ready converter from the adder's custom float result to IEEE-754 binary32.
// Rounding mode is selected by FP_CONV_ROUND_RNE_EN (see fp_round_pack).
module fp_result_ieee_conv
    import fp_custom_pkg::*;
#(
    parameter int                CNT_W       = 16,
    parameter logic [IEEE_W-1:0] NAN_PATTERN = 32'h7FC0_0000
) (
    input  logic                clock_100kHz,
    input  logic                reset,
    input  logic [IEEE_W-1:0]   in_data,
    input  logic [STATUS_W-1:0] in_status,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [IEEE_W-1:0]   out_data,
    output logic [STATUS_W-1:0] out_status,
    output logic [FLAG_W-1:0]   out_flags,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    inexact_cnt
);

    custom_fp_t          in_word;
    logic                s1_valid;
    logic                s1_sign;
    fp_class_t           s1_class;
    logic [EXP_W-1:0]    s1_exp;
    logic [MAN_W-1:0]    s1_man;
    logic [STATUS_W-1:0] s1_status;
    logic                s1_adv;
    logic [IEEE_W-1:0]   pack_data;
    logic [FLAG_W-1:0]   pack_flags;

    assign in_word  = in_data;
    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_class  <= ZERO;
            s1_exp    <= '0;
            s1_man    <= '0;
            s1_status <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_word.sign;
                s1_class  <= classify(in_word);
                s1_exp    <= in_word.exp;
                s1_man    <= in_word.man;
                s1_status <= in_status;
            end
        end
    end

    fp_round_pack #(
        .NAN_PATTERN (NAN_PATTERN)
    ) u_round_pack (
        .sign  (s1_sign),
        .cls   (s1_class),
        .exp   (s1_exp),
        .man   (s1_man),
        .data  (pack_data),
        .flags (pack_flags)
    );

    // Output registers form stage 2; they only load when the consumer side can move.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= '0;
            out_flags  <= '0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= pack_data;
                out_status <= s1_status;
                out_flags  <= pack_flags;
            end
        end
    end

    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            inexact_cnt <= '0;
        end else if (out_valid && out_ready && out_flags[FLAG_INEXACT] && (inexact_cnt != '1)) begin
            inexact_cnt <= inexact_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_result_ieee_conv.sv
// Scoreboard bench for fp_result_ieee_conv; expectations follow FP_CONV_ROUND_RNE_EN like the DUT.
module tb_fp_result_ieee_conv;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  status;
        logic [3:0]  flags;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [31:0]      in_data;
    logic [3:0]       in_status;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      out_data;
    logic [3:0]       out_status;
    logic [3:0]       out_flags;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] inexact_cnt;

    fp_result_ieee_conv #(
        .CNT_W       (CNT_W),
        .NAN_PATTERN (32'h7FC0_0000)
    ) dut (
        .clock_100kHz (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_status    (in_status),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .out_flags    (out_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .inexact_cnt  (inexact_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t             sb[$];
    exp_t             cur_exp;
    logic             accepted;
    logic [CNT_W-1:0] model_cnt;
    int               n_vec;
    int               n_err;

    function automatic exp_t mk(input logic [31:0] d, input logic [3:0] st, input logic [3:0] fl);
        exp_t r;
        r.data   = d;
        r.status = st;
        r.flags  = fl;
        return r;
    endfunction

    // Reference conversion written from the format definition in integer arithmetic.
    function automatic exp_t model(input logic [31:0] w, input logic [3:0] st);
        exp_t        r;
        int          e;
        int          ex;
        int unsigned m;
        int unsigned frac;
        int unsigned rem;
        e        = int'(w[30:25]);
        m        = int'(w[24:0]);
        r.status = st;
        r.flags  = 4'b0000;
        if (e == 0) begin
            r.data  = {w[31], 31'b0};
            r.flags = 4'b0010;
        end else if (e == 63) begin
            if (m == 0) begin
                r.data  = {w[31], 8'hFF, 23'b0};
                r.flags = 4'b0100;
            end else begin
                r.data  = 32'h7FC0_0000;
                r.flags = 4'b1000;
            end
        end else begin
            ex   = e - 31 + 127;
            frac = m >> 2;
            rem  = m & 3;
`ifdef FP_CONV_ROUND_RNE_EN
            if (rem == 3 || (rem == 2 && (frac % 2) == 1))
                frac = frac + 1;
`endif
            if (frac == (1 << 23)) begin
                frac = 0;
                ex   = ex + 1;
            end
            r.data  = {w[31], 8'(ex), 23'(frac)};
            r.flags = (rem != 0) ? 4'b0001 : 4'b0000;
        end
        return r;
    endfunction

    // One clock: check any output transfer against the scoreboard, record an input transfer.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (!reset && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_output: got data=%h status=%h flags=%b, expected no output",
                         out_data, out_status, out_flags);
            end else begin
                e = sb.pop_front();
                if (out_data !== e.data || out_status !== e.status || out_flags !== e.flags) begin
                    n_err++;
                    $display("FAIL sb_output: got data=%h status=%h flags=%b, expected data=%h status=%h flags=%b",
                             out_data, out_status, out_flags, e.data, e.status, e.flags);
                end
                if (e.flags[0] && model_cnt != '1)
                    model_cnt = model_cnt + 1'b1;
            end
        end
        if (!reset && in_valid && in_ready) begin
            accepted = 1'b1;
            sb.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] st, input exp_t e);
        in_data   = d;
        in_status = st;
        in_valid  = 1'b1;
        cur_exp   = e;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles, expected acceptance", d);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++)
            tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        tick();
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_status !== 4'h0 || out_flags !== 4'h0 ||
            inexact_cnt !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b data=%h status=%h flags=%b cnt=%0d in_ready=%b, expected 0/0/0/0/0/1",
                     out_valid, out_data, out_status, out_flags, inexact_cnt, in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(32'h3E00_0000, 4'h5, mk(32'h3F80_0000, 4'h5, 4'b0000));
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, expected 0", out_valid);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000) begin
            n_err++;
            $display("FAIL latency_two: got valid=%b data=%h, expected 1 and 3f800000", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(32'hBF00_0000, 4'hA, mk(32'hBFC0_0000, 4'hA, 4'b0000));
        send(32'h4000_0000, 4'h3, mk(32'h4000_0000, 4'h3, 4'b0000));
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hBFC0_0000) begin
            n_err++;
            $display("FAIL back_to_back: got valid=%b data=%h, expected 1 and bfc00000", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_rounding();
        logic [31:0] ins [4];
        logic [31:0] outs[4];
        ins = '{32'h3E00_0003, 32'h3E00_0002, 32'h3E00_0006, 32'h3FFF_FFFF};
`ifdef FP_CONV_ROUND_RNE_EN
        outs = '{32'h3F80_0001, 32'h3F80_0000, 32'h3F80_0002, 32'h4000_0000};
`else
        outs = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h3FFF_FFFF};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            send(ins[i], 4'(i), mk(outs[i], 4'(i), 4'b0001));
        drain();
    endtask

    task automatic test_specials();
        out_ready = 1'b1;
        send(32'h0123_4567, 4'h1, mk(32'h0000_0000, 4'h1, 4'b0010));
        send(32'h7E00_0000, 4'h2, mk(32'h7F80_0000, 4'h2, 4'b0100));
        send(32'hFE00_0001, 4'h4, mk(32'h7FC0_0000, 4'h4, 4'b1000));
        send(32'h8000_0007, 4'h8, mk(32'h8000_0000, 4'h8, 4'b0010));
        send(32'hFE00_0000, 4'hF, mk(32'hFF80_0000, 4'hF, 4'b0100));
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(32'h3E00_0000, 4'h1, mk(32'h3F80_0000, 4'h1, 4'b0000));
        send(32'hBF00_0000, 4'h2, mk(32'hBFC0_0000, 4'h2, 4'b0000));
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready: got in_ready=%b with both stages full, expected 0", in_ready);
        end
        in_data   = 32'h4000_0000;
        in_status = 4'h3;
        in_valid  = 1'b1;
        cur_exp   = mk(32'h4000_0000, 4'h3, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (accepted || out_valid !== 1'b1 || out_data !== 32'h3F80_0000 || out_status !== 4'h1) begin
                n_err++;
                $display("FAIL bp_hold: got accepted=%b valid=%b data=%h status=%h, expected 0/1/3f800000/1",
                         accepted, out_valid, out_data, out_status);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !accepted; i++)
            tick();
        n_vec++;
        if (!accepted) begin
            n_err++;
            $display("FAIL bp_release: third word accepted=%b after release, expected 1", accepted);
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_counter();
        n_vec++;
        if (inexact_cnt !== model_cnt) begin
            n_err++;
            $display("FAIL inexact_cnt: got %0d, expected %0d", inexact_cnt, model_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [3:0]  st;
        int          sel;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || accepted) begin
                if ($urandom_range(0, 3) != 0) begin
                    w   = $urandom;
                    st  = 4'($urandom);
                    sel = $urandom_range(0, 7);
                    if (sel == 0) w[30:25] = 6'd0;
                    else if (sel == 1) w[30:25] = 6'd63;
                    else if (sel == 2) w[24:0] = 25'h0;
                    else if (sel == 3) w[1:0] = 2'b10;
                    in_data   = w;
                    in_status = st;
                    in_valid  = 1'b1;
                    cur_exp   = model(w, st);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(32'h3E00_0003, 4'h6, mk(32'h0, 4'h0, 4'b0000));
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || inexact_cnt === '0) begin
            n_err++;
            $display("FAIL midstream_setup: got valid=%b cnt=%0d, expected valid 1 and nonzero count",
                     out_valid, inexact_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || inexact_cnt !== '0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b cnt=%0d data=%h in_ready=%b, expected 0/0/0/1",
                     out_valid, inexact_cnt, out_data, in_ready);
        end
        sb.delete();
        model_cnt = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        send(32'h4000_0000, 4'h9, mk(32'h4000_0000, 4'h9, 4'b0000));
        drain();
        test_counter();
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        model_cnt = '0;
        accepted  = 1'b0;
        cur_exp   = '0;
        reset     = 1'b1;
        in_data   = '0;
        in_status = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_basic();
        test_back_to_back();
        test_rounding();
        test_counter();
        test_specials();
        test_backpressure();
        test_counter();
        test_random();
        test_counter();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
